// File: rtl/aww_types_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : aww_types_pkg
//  Description : Shared types and constants for the aww pipeline front end.
//  Revision    : 1.0  initial release
// ============================================================================
package aww_types_pkg;

    typedef logic [31:0] word_t;

    localparam word_t PC_STEP = 32'd4;

    // Explicit 2-bit encoding so the state register width is fixed.
    typedef enum logic [1:0] {
        FETCH   = 2'd0,
        PENDING = 2'd1,
        HALTED  = 2'd2
    } fetch_state_t;

    typedef struct packed {
        logic  valid;
        logic  is_branch;
        word_t target;
    } redirect_t;

    // Instruction addresses are word aligned; low bits of a target are dropped.
    function automatic word_t align_target(input word_t t);
        return {t[31:2], 2'b00};
    endfunction

endpackage
`default_nettype wire

// File: rtl/fetch_redirect_buf.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_redirect_buf
//  Description : Holds a redirect across stalls and resolves branch/jump
//                priority, presenting the single live redirect.
//  Revision    : 1.0  initial release
// ============================================================================
module fetch_redirect_buf
    import aww_types_pkg::*;
(
    input  logic      CLK,
    input  logic      RST,
    input  logic      en_i,        // redirects may be live this cycle
    input  logic      hold_i,      // keep the live redirect for next cycle
    input  logic      br_taken_i,
    input  word_t     br_target_i,
    input  logic      jmp_valid_i,
    input  word_t     jmp_target_i,
    output redirect_t live_o
);

    redirect_t buf_q;
    redirect_t buf_d;
    redirect_t incoming;
    redirect_t live;

    // Resolve incoming vs buffered redirect; branch is always the older instruction.
    always_comb begin
        incoming = '0;
        if (br_taken_i) begin
            incoming.valid     = 1'b1;
            incoming.is_branch = 1'b1;
            incoming.target    = align_target(br_target_i);
        end else if (jmp_valid_i) begin
            incoming.valid     = 1'b1;
            incoming.is_branch = 1'b0;
            incoming.target    = align_target(jmp_target_i);
        end

        if (buf_q.valid) begin
            // A buffered jump loses to a new branch; a buffered branch makes
            // any newer jump a wrong-path one.
            if (!buf_q.is_branch && incoming.valid && incoming.is_branch) begin
                live = incoming;
            end else begin
                live = buf_q;
            end
        end else begin
            live = incoming;
        end

        if (!en_i) begin
            live = '0;
        end

        buf_d  = hold_i ? live : '0;
        live_o = live;
    end

    // Buffer register; cleared by reset and whenever the redirect is consumed.
    always_ff @(posedge CLK) begin
        if (RST) begin
            buf_q <= '0;
        end else begin
            buf_q <= buf_d;
        end
    end

endmodule
`default_nettype wire

// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_unit
//  Description : Instruction-fetch stage: PC register, redirect handling,
//                halt freeze and IF/ID presentation.
//  Revision    : 1.0  initial release
// ============================================================================
module fetch_unit
    import aww_types_pkg::*;
#(
    parameter logic [31:0] PC_INIT = 32'h0000_0000
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        pc_WEN,
    input  logic        dpif_ihit,
    input  logic [31:0] imemload,
    input  logic        br_taken,
    input  logic [31:0] br_target,
    input  logic        jmp_valid,
    input  logic [31:0] jmp_target,
    input  logic        exmem_halt,
    output logic        imemREN,
    output logic [31:0] imemaddr,
    output logic        fetch_valid,
    output logic [31:0] fetch_instr,
    output logic [31:0] fetch_pc,
    output logic [31:0] fetch_npc,
    output logic        npc_change,
    output logic [0:1]  flushes,
    output logic        halted
);

    fetch_state_t state_q;
    fetch_state_t state_d;
    word_t        pc_q;
    word_t        pc_d;
    word_t        pc_plus4;
    redirect_t    live;
    logic         redir_en;
    logic         redir_hold;

    assign pc_plus4 = pc_q + PC_STEP;

    // Halt and reset both outrank any redirect; nothing is live while halted.
    assign redir_en   = !RST && !exmem_halt && (state_q != HALTED);
    assign redir_hold = redir_en && !pc_WEN;

    fetch_redirect_buf u_redirect_buf (
        .CLK          (CLK),
        .RST          (RST),
        .en_i         (redir_en),
        .hold_i       (redir_hold),
        .br_taken_i   (br_taken),
        .br_target_i  (br_target),
        .jmp_valid_i  (jmp_valid),
        .jmp_target_i (jmp_target),
        .live_o       (live)
    );

    // State and PC registers.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= FETCH;
            pc_q    <= PC_INIT;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
        end
    end

    // Next-state and next-PC selection.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        if (exmem_halt) begin
            state_d = HALTED;
        end else begin
            case (state_q)
                FETCH: begin
                    if (pc_WEN) begin
                        pc_d = live.valid ? live.target : pc_plus4;
                    end else if (live.valid) begin
                        state_d = PENDING;
                    end
                end
                PENDING: begin
                    if (pc_WEN) begin
                        pc_d    = live.target;
                        state_d = FETCH;
                    end
                end
                HALTED: begin
                    state_d = HALTED;
                end
                default: begin
                    state_d = FETCH;
                end
            endcase
        end
    end

    // Output decode; flushes[0] is IF/ID, flushes[1] is ID/EX (branch only).
    always_comb begin
        imemREN     = !RST && (state_q != HALTED);
        npc_change  = live.valid;
        flushes     = live.valid ? {1'b1, live.is_branch} : 2'b00;
        fetch_valid = dpif_ihit && imemREN && !npc_change;
        fetch_instr = imemload;
        fetch_pc    = pc_q;
        fetch_npc   = pc_plus4;
        imemaddr    = pc_q;
        halted      = (state_q == HALTED);
    end

endmodule
`default_nettype wire

// File: tb/tb_fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fetch_unit
//  Description : Directed self-checking bench for fetch_unit.
//  Revision    : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
module tb_fetch_unit;

    logic        CLK = 1'b0;
    logic        RST = 1'b0;
    logic        pc_WEN = 1'b0;
    logic        dpif_ihit = 1'b0;
    logic [31:0] imemload = 32'hDEAD_BEEF;
    logic        br_taken = 1'b0;
    logic [31:0] br_target = 32'h0;
    logic        jmp_valid = 1'b0;
    logic [31:0] jmp_target = 32'h0;
    logic        exmem_halt = 1'b0;
    logic        imemREN;
    logic [31:0] imemaddr;
    logic        fetch_valid;
    logic [31:0] fetch_instr;
    logic [31:0] fetch_pc;
    logic [31:0] fetch_npc;
    logic        npc_change;
    logic [0:1]  flushes;
    logic        halted;

    int checks   = 0;
    int failures = 0;

    fetch_unit #(.PC_INIT(32'h0000_0000)) dut (
        .CLK         (CLK),
        .RST         (RST),
        .pc_WEN      (pc_WEN),
        .dpif_ihit   (dpif_ihit),
        .imemload    (imemload),
        .br_taken    (br_taken),
        .br_target   (br_target),
        .jmp_valid   (jmp_valid),
        .jmp_target  (jmp_target),
        .exmem_halt  (exmem_halt),
        .imemREN     (imemREN),
        .imemaddr    (imemaddr),
        .fetch_valid (fetch_valid),
        .fetch_instr (fetch_instr),
        .fetch_pc    (fetch_pc),
        .fetch_npc   (fetch_npc),
        .npc_change  (npc_change),
        .flushes     (flushes),
        .halted      (halted)
    );

    always #5 CLK = ~CLK;

    // Advance one clock; inputs change and outputs are sampled 1ns after the edge.
    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic do_reset();
        RST = 1'b1; pc_WEN = 1'b1; dpif_ihit = 1'b1;
        br_taken = 1'b0; jmp_valid = 1'b0; exmem_halt = 1'b0;
        tick();
        RST = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        RST = 1'b1; pc_WEN = 1'b1; dpif_ihit = 1'b1;
        tick();
        tick();
        checks++; if (imemREN !== 1'b0) begin failures++; $display("FAIL rst_imemREN got %b want 0", imemREN); end
        checks++; if (fetch_valid !== 1'b0) begin failures++; $display("FAIL rst_fetch_valid got %b want 0", fetch_valid); end
        checks++; if (npc_change !== 1'b0) begin failures++; $display("FAIL rst_npc_change got %b want 0", npc_change); end
        checks++; if (flushes !== 2'b00) begin failures++; $display("FAIL rst_flushes got %b want 00", flushes); end
        checks++; if (halted !== 1'b0) begin failures++; $display("FAIL rst_halted got %b want 0", halted); end
        checks++; if (imemaddr !== 32'h0) begin failures++; $display("FAIL rst_imemaddr got %h want 0", imemaddr); end
        checks++; if (fetch_npc !== 32'h4) begin failures++; $display("FAIL rst_fetch_npc got %h want 4", fetch_npc); end
        RST = 1'b0;
        #1;
    endtask

    task automatic test_sequential();
        for (int i = 0; i < 4; i++) begin
            checks++; if (imemaddr !== 32'(4 * i)) begin failures++; $display("FAIL seq_addr got %h want %h", imemaddr, 32'(4 * i)); end
            checks++; if (fetch_valid !== 1'b1) begin failures++; $display("FAIL seq_fetch_valid got %b want 1", fetch_valid); end
            checks++; if (fetch_pc !== 32'(4 * i)) begin failures++; $display("FAIL seq_fetch_pc got %h want %h", fetch_pc, 32'(4 * i)); end
            tick();
        end
    endtask

    task automatic test_jump();
        do_reset();
        tick();
        tick();
        checks++; if (imemaddr !== 32'h8) begin failures++; $display("FAIL jmp_start got %h want 8", imemaddr); end
        jmp_valid = 1'b1; jmp_target = 32'h100;
        #1;
        checks++; if (npc_change !== 1'b1) begin failures++; $display("FAIL jmp_npc_change got %b want 1", npc_change); end
        checks++; if (flushes !== 2'b10) begin failures++; $display("FAIL jmp_flushes got %b want 10", flushes); end
        checks++; if (fetch_valid !== 1'b0) begin failures++; $display("FAIL jmp_fetch_valid got %b want 0", fetch_valid); end
        tick();
        jmp_valid = 1'b0;
        #1;
        checks++; if (imemaddr !== 32'h100) begin failures++; $display("FAIL jmp_addr got %h want 100", imemaddr); end
        checks++; if (npc_change !== 1'b0) begin failures++; $display("FAIL jmp_npc_clear got %b want 0", npc_change); end
        checks++; if (fetch_valid !== 1'b1) begin failures++; $display("FAIL jmp_fv_after got %b want 1", fetch_valid); end
    endtask

    task automatic test_branch_stall();
        pc_WEN = 1'b0; br_taken = 1'b1; br_target = 32'h200;
        for (int c = 0; c < 3; c++) begin
            #1;
            checks++; if (imemaddr !== 32'h100) begin failures++; $display("FAIL bst_hold c%0d got %h want 100", c, imemaddr); end
            checks++; if (flushes !== 2'b11) begin failures++; $display("FAIL bst_flushes c%0d got %b want 11", c, flushes); end
            checks++; if (npc_change !== 1'b1) begin failures++; $display("FAIL bst_npc c%0d got %b want 1", c, npc_change); end
            tick();
            br_taken = 1'b0;
        end
        pc_WEN = 1'b1;
        #1;
        checks++; if (flushes !== 2'b11) begin failures++; $display("FAIL bst_release_flushes got %b want 11", flushes); end
        tick();
        checks++; if (imemaddr !== 32'h200) begin failures++; $display("FAIL bst_addr got %h want 200", imemaddr); end
        checks++; if (npc_change !== 1'b0) begin failures++; $display("FAIL bst_npc_clear got %b want 0", npc_change); end
    endtask

    task automatic test_priority();
        // Same-cycle jump and branch while PC is 0x200: branch wins.
        jmp_valid = 1'b1; jmp_target = 32'h100; br_taken = 1'b1; br_target = 32'h200;
        #1;
        checks++; if (flushes !== 2'b11) begin failures++; $display("FAIL pri_same_flushes got %b want 11", flushes); end
        tick();
        jmp_valid = 1'b0; br_taken = 1'b0;
        #1;
        checks++; if (imemaddr !== 32'h200) begin failures++; $display("FAIL pri_same_addr got %h want 200", imemaddr); end
        // Buffered jump overwritten by a later branch.
        pc_WEN = 1'b0; jmp_valid = 1'b1; jmp_target = 32'h100;
        tick();
        jmp_valid = 1'b0; br_taken = 1'b1; br_target = 32'h300;
        #1;
        checks++; if (flushes !== 2'b11) begin failures++; $display("FAIL pri_ovr_flushes got %b want 11", flushes); end
        tick();
        br_taken = 1'b0;
        checks++; if (imemaddr !== 32'h200) begin failures++; $display("FAIL pri_ovr_hold got %h want 200", imemaddr); end
        pc_WEN = 1'b1;
        tick();
        checks++; if (imemaddr !== 32'h300) begin failures++; $display("FAIL pri_ovr_addr got %h want 300", imemaddr); end
        // Buffered branch ignores a later wrong-path jump.
        pc_WEN = 1'b0; br_taken = 1'b1; br_target = 32'h380;
        tick();
        br_taken = 1'b0; jmp_valid = 1'b1; jmp_target = 32'h100;
        tick();
        jmp_valid = 1'b0; pc_WEN = 1'b1;
        #1;
        checks++; if (flushes !== 2'b11) begin failures++; $display("FAIL pri_keep_flushes got %b want 11", flushes); end
        tick();
        checks++; if (imemaddr !== 32'h380) begin failures++; $display("FAIL pri_keep_addr got %h want 380", imemaddr); end
    endtask

    task automatic test_halt();
        do_reset();
        jmp_valid = 1'b1; jmp_target = 32'h40;
        tick();
        jmp_valid = 1'b0;
        #1;
        checks++; if (imemaddr !== 32'h40) begin failures++; $display("FAIL hlt_start got %h want 40", imemaddr); end
        exmem_halt = 1'b1; br_taken = 1'b1; br_target = 32'h200;
        tick();
        exmem_halt = 1'b0; br_taken = 1'b0;
        #1;
        for (int c = 0; c < 10; c++) begin
            checks++; if (halted !== 1'b1) begin failures++; $display("FAIL hlt_halted c%0d got %b want 1", c, halted); end
            checks++; if (imemREN !== 1'b0) begin failures++; $display("FAIL hlt_imemREN c%0d got %b want 0", c, imemREN); end
            checks++; if (imemaddr !== 32'h40) begin failures++; $display("FAIL hlt_pc c%0d got %h want 40", c, imemaddr); end
            tick();
        end
        RST = 1'b1;
        tick();
        RST = 1'b0;
        #1;
        checks++; if (imemaddr !== 32'h0) begin failures++; $display("FAIL hlt_rst_pc got %h want 0", imemaddr); end
        checks++; if (halted !== 1'b0) begin failures++; $display("FAIL hlt_rst_halted got %b want 0", halted); end
    endtask

    task automatic test_wrap_reset();
        jmp_valid = 1'b1; jmp_target = 32'hFFFF_FFFC;
        tick();
        jmp_valid = 1'b0;
        #1;
        checks++; if (imemaddr !== 32'hFFFF_FFFC) begin failures++; $display("FAIL wrap_start got %h want fffffffc", imemaddr); end
        checks++; if (fetch_npc !== 32'h0) begin failures++; $display("FAIL wrap_npc got %h want 0", fetch_npc); end
        tick();
        checks++; if (imemaddr !== 32'h0) begin failures++; $display("FAIL wrap_addr got %h want 0", imemaddr); end
        br_taken = 1'b1; br_target = 32'h203;
        tick();
        br_taken = 1'b0;
        #1;
        checks++; if (imemaddr !== 32'h200) begin failures++; $display("FAIL align_addr got %h want 200", imemaddr); end
        pc_WEN = 1'b0; br_taken = 1'b1; br_target = 32'h300;
        tick();
        br_taken = 1'b0;
        #1;
        checks++; if (npc_change !== 1'b1) begin failures++; $display("FAIL rpend_npc got %b want 1", npc_change); end
        RST = 1'b1;
        #1;
        checks++; if (npc_change !== 1'b0) begin failures++; $display("FAIL rpend_npc_in_rst got %b want 0", npc_change); end
        tick();
        RST = 1'b0;
        #1;
        checks++; if (npc_change !== 1'b0) begin failures++; $display("FAIL rpend_npc_after got %b want 0", npc_change); end
        checks++; if (imemaddr !== 32'h0) begin failures++; $display("FAIL rpend_pc got %h want 0", imemaddr); end
        pc_WEN = 1'b1;
        tick();
        checks++; if (imemaddr !== 32'h4) begin failures++; $display("FAIL rpend_seq got %h want 4", imemaddr); end
    endtask

    initial begin
        #2;
        test_reset();
        test_sequential();
        test_jump();
        test_branch_stall();
        test_priority();
        test_halt();
        test_wrap_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
